// File: rtl/wfg_record_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wfg_record_spi_pkg
// Description : Shared constants for the SPI record (capture) block: register
//               byte offsets, CTRL/STATUS bit positions, WSIZE reset value and
//               the capture FSM state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wfg_record_spi_pkg;

  // Register byte offsets within the 16-byte page
  localparam logic [3:0] c_reg_ctrl   = 4'h0;
  localparam logic [3:0] c_reg_wsize  = 4'h4;
  localparam logic [3:0] c_reg_status = 4'h8;
  localparam logic [3:0] c_reg_last   = 4'hC;

  // CTRL bit positions
  localparam int c_ctrl_en        = 0;
  localparam int c_ctrl_cpol      = 1;
  localparam int c_ctrl_cpha      = 2;
  localparam int c_ctrl_lsb_first = 3;

  // STATUS bit positions
  localparam int c_stat_ovf  = 0;
  localparam int c_stat_ferr = 1;
  localparam int c_stat_busy = 2;

  // WSIZE holds bits-1; reset selects 32-bit words
  localparam logic [4:0] c_wsize_rst = 5'h1F;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/wfg_record_spi_wishbone_reg.sv
`default_nettype none
// ============================================================================
// Module      : wfg_record_spi_wishbone_reg
// Description : Wishbone register page for the SPI record block. Holds CTRL
//               and WSIZE, the sticky W1C STATUS flags, generates the
//               one-cycle ack and a registered read mux.
// Ports       : clk/rst            - clock, synchronous active-high reset
//               i_wbs_*            - Wishbone slave inputs
//               o_wbs_ack/dat      - Wishbone ack and read data
//               o_en..o_wsize      - configuration to the capture datapath
//               i_busy             - FSM in SHIFT
//               i_set_ovf/ferr     - one-cycle set pulses for STATUS flags
//               i_last             - last word loaded into the AXIS stage
// Revision    : 1.0 - initial release
// ============================================================================
module wfg_record_spi_wishbone_reg
  import wfg_record_spi_pkg::*;
#(
  parameter int BUSW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wbs_stb,
  input  logic            i_wbs_cyc,
  input  logic            i_wbs_we,
  input  logic [3:0]      i_wbs_sel,
  input  logic [BUSW-1:0] i_wbs_dat,
  input  logic [BUSW-1:0] i_wbs_adr,
  output logic            o_wbs_ack,
  output logic [BUSW-1:0] o_wbs_dat,
  output logic            o_en,
  output logic            o_cpol,
  output logic            o_cpha,
  output logic            o_lsb_first,
  output logic [4:0]      o_wsize,
  input  logic            i_busy,
  input  logic            i_set_ovf,
  input  logic            i_set_ferr,
  input  logic [31:0]     i_last
);

  logic            ack_q,   ack_d;
  logic [BUSW-1:0] dat_q,   dat_d;
  logic [3:0]      ctrl_q,  ctrl_d;
  logic [4:0]      wsize_q, wsize_d;
  logic            ovf_q,   ovf_d;
  logic            ferr_q,  ferr_d;

  logic        w_acc;
  logic        w_wr;
  logic [3:0]  w_off;
  logic [31:0] w_rdata;
  logic        w_unused_ok;

  // Only address bits [3:2] and byte lane 0 carry meaning in this page
  assign w_unused_ok = ^{i_wbs_adr[BUSW-1:4], i_wbs_adr[1:0],
                         i_wbs_dat[BUSW-1:5], i_wbs_sel[3:1]};

  always_comb begin
    // Accept once per strobe; the ack itself blocks a second access
    w_acc = i_wbs_stb & i_wbs_cyc & ~ack_q;
    // Every field lives in byte lane 0
    w_wr  = w_acc & i_wbs_we & i_wbs_sel[0];
    w_off = {i_wbs_adr[3:2], 2'b00};
    ack_d = w_acc;

    ctrl_d = ctrl_q;
    if (w_wr && (w_off == c_reg_ctrl)) ctrl_d = i_wbs_dat[3:0];

    wsize_d = wsize_q;
    if (w_wr && (w_off == c_reg_wsize)) wsize_d = i_wbs_dat[4:0];

    // W1C first, hardware set afterwards so a coincident set wins
    ovf_d = ovf_q;
    if (w_wr && (w_off == c_reg_status) && i_wbs_dat[c_stat_ovf]) ovf_d = 1'b0;
    if (i_set_ovf) ovf_d = 1'b1;

    ferr_d = ferr_q;
    if (w_wr && (w_off == c_reg_status) && i_wbs_dat[c_stat_ferr]) ferr_d = 1'b0;
    if (i_set_ferr) ferr_d = 1'b1;

    w_rdata = '0;
    case (w_off)
      c_reg_ctrl:  w_rdata[3:0] = ctrl_q;
      c_reg_wsize: w_rdata[4:0] = wsize_q;
      c_reg_status: begin
        w_rdata[c_stat_ovf]  = ovf_q;
        w_rdata[c_stat_ferr] = ferr_q;
        w_rdata[c_stat_busy] = i_busy;
      end
      c_reg_last:  w_rdata = i_last;
      default:     w_rdata = '0;
    endcase

    dat_d = w_acc ? BUSW'(w_rdata) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ctrl_q  <= '0;
      wsize_q <= c_wsize_rst;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      ctrl_q  <= ctrl_d;
      wsize_q <= wsize_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_wbs_ack   = ack_q;
  assign o_wbs_dat   = dat_q;
  assign o_en        = ctrl_q[c_ctrl_en];
  assign o_cpol      = ctrl_q[c_ctrl_cpol];
  assign o_cpha      = ctrl_q[c_ctrl_cpha];
  assign o_lsb_first = ctrl_q[c_ctrl_lsb_first];
  assign o_wsize     = wsize_q;

endmodule
`default_nettype wire

// File: rtl/wfg_record_spi_top.sv
`default_nettype none
// ============================================================================
// Module      : wfg_record_spi_top
// Description : SPI slave-side capture for the waveform generator. Oversamples
//               sclk/cs_n/sdi in the Wishbone clock domain, deserialises
//               1..32 bit words and presents them on an AXI-Stream master.
// Ports       : wb_clk_i/wb_rst_i          - clock, sync active-high reset
//               wbs_*                      - Wishbone slave register page
//               wfg_record_spi_*           - asynchronous SPI inputs
//               wfg_axis_tready_i          - downstream ready
//               wfg_axis_tvalid_o/tdata_o  - received word, right-justified
// Revision    : 1.0 - initial release
// ============================================================================
module wfg_record_spi_top
  import wfg_record_spi_pkg::*;
#(
  parameter int BUSW        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [BUSW-1:0] wbs_dat_i,
  input  logic [BUSW-1:0] wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [BUSW-1:0] wbs_dat_o,
  input  logic            wfg_record_spi_sclk_i,
  input  logic            wfg_record_spi_cs_ni,
  input  logic            wfg_record_spi_sdi_i,
  input  logic            wfg_axis_tready_i,
  output logic            wfg_axis_tvalid_o,
  output logic [31:0]     wfg_axis_tdata_o
);

  // Configuration from the register page
  logic       w_en;
  logic       w_cpol;
  logic       w_cpha;
  logic       w_lsb_first;
  logic [4:0] w_wsize;

  // Synchroniser chains, all the same depth so sdi stays aligned with sclk
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q,  sdi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] shift_q, shift_d;
  logic        tvalid_q, tvalid_d;
  logic [31:0] tdata_q,  tdata_d;

  logic        w_sclk;
  logic        w_cs_n;
  logic        w_sdi;
  logic        w_sample;
  logic [31:0] w_word;
  logic        w_word_done;
  logic        w_set_ovf;
  logic        w_set_ferr;
  logic        w_busy;

  wfg_record_spi_wishbone_reg #(
    .BUSW (BUSW)
  ) u_reg (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .i_wbs_stb   (wbs_stb_i),
    .i_wbs_cyc   (wbs_cyc_i),
    .i_wbs_we    (wbs_we_i),
    .i_wbs_sel   (wbs_sel_i),
    .i_wbs_dat   (wbs_dat_i),
    .i_wbs_adr   (wbs_adr_i),
    .o_wbs_ack   (wbs_ack_o),
    .o_wbs_dat   (wbs_dat_o),
    .o_en        (w_en),
    .o_cpol      (w_cpol),
    .o_cpha      (w_cpha),
    .o_lsb_first (w_lsb_first),
    .o_wsize     (w_wsize),
    .i_busy      (w_busy),
    .i_set_ovf   (w_set_ovf),
    .i_set_ferr  (w_set_ferr),
    .i_last      (tdata_q)
  );

  // ---------------------------------------------------------------- sync
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], wfg_record_spi_sclk_i};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   wfg_record_spi_cs_ni};
    sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0],  wfg_record_spi_sdi_i};

    w_sclk      = sclk_sync_q[SYNC_STAGES-1];
    w_cs_n      = cs_sync_q[SYNC_STAGES-1];
    w_sdi       = sdi_sync_q[SYNC_STAGES-1];
    sclk_hist_d = w_sclk;

    // Modes 0/3 sample on rising sclk, modes 1/2 on falling sclk
    if (w_cpol ^ w_cpha) w_sample = ~w_sclk &  sclk_hist_q;
    else                 w_sample =  w_sclk & ~sclk_hist_q;
  end

  // ------------------------------------------------------- state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (w_en && !w_cs_n) state_d = ST_SHIFT;
      ST_SHIFT: if (!w_en || w_cs_n) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------- outputs / datapath logic
  always_comb begin
    w_busy      = (state_q == ST_SHIFT);
    count_d     = count_q;
    shift_d     = shift_q;
    w_word_done = 1'b0;
    w_set_ferr  = 1'b0;

    // Shift register contents including the bit being sampled this cycle
    if (w_lsb_first) begin
      w_word          = shift_q;
      w_word[count_q] = w_sdi;
    end else begin
      w_word = {shift_q[30:0], w_sdi};
    end

    case (state_q)
      ST_SHIFT: begin
        if (!w_en) begin
          // Disable discards the partial word silently
          count_d = '0;
          shift_d = '0;
        end else if (w_cs_n) begin
          if (count_q != 5'd0) w_set_ferr = 1'b1;
          count_d = '0;
          shift_d = '0;
        end else if (w_sample) begin
          if (count_q == w_wsize) begin
            // Clearing keeps the next word's unused upper bits zero
            w_word_done = 1'b1;
            count_d     = '0;
            shift_d     = '0;
          end else begin
            count_d = count_q + 5'd1;
            shift_d = w_word;
          end
        end
      end
      default: begin
        count_d = '0;
        shift_d = '0;
      end
    endcase

    // Single-register AXIS stage; a completing word may reuse the slot in
    // the same cycle its predecessor is accepted
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    w_set_ovf = 1'b0;
    if (tvalid_q && wfg_axis_tready_i) tvalid_d = 1'b0;
    if (w_word_done) begin
      if (!tvalid_q || wfg_axis_tready_i) begin
        tdata_d  = w_word;
        tvalid_d = 1'b1;
      end else begin
        w_set_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
      sclk_hist_q <= 1'b0;
      count_q     <= '0;
      shift_q     <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
    end
  end

  assign wfg_axis_tvalid_o = tvalid_q;
  assign wfg_axis_tdata_o  = tdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wfg_record_spi_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_wfg_record_spi_top
// Description : Self-checking bench for wfg_record_spi_top. Drives SPI frames
//               in all four modes, both bit orders and random word sizes, and
//               compares received AXIS words and register contents against
//               values derived from the transmitted data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wfg_record_spi_top;

  localparam int H = 3;  // SPI half period in wb clocks

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic        sclk, cs_n, sdi;
  logic        tready, tvalid;
  logic [31:0] tdata;

  int n_pass  = 0;
  int n_total = 0;
  int cyc_cnt = 0;
  int valid_cycles;
  int rise_cyc;
  int last_sample_cyc;
  logic tvalid_prev;

  logic [31:0] got_q[$];
  logic [31:0] tx_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wfg_record_spi_top #(
    .BUSW        (32),
    .SYNC_STAGES (2)
  ) dut (
    .wb_clk_i              (clk),
    .wb_rst_i              (rst),
    .wbs_stb_i             (stb),
    .wbs_cyc_i             (cyc),
    .wbs_we_i              (we),
    .wbs_sel_i             (sel),
    .wbs_dat_i             (dat_i),
    .wbs_adr_i             (adr),
    .wbs_ack_o             (ack),
    .wbs_dat_o             (dat_o),
    .wfg_record_spi_sclk_i (sclk),
    .wfg_record_spi_cs_ni  (cs_n),
    .wfg_record_spi_sdi_i  (sdi),
    .wfg_axis_tready_i     (tready),
    .wfg_axis_tvalid_o     (tvalid),
    .wfg_axis_tdata_o      (tdata)
  );

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // AXIS monitor: inputs only change 2ns after posedge, so negedge sees the
  // values that the next posedge will act on
  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid && tready) got_q.push_back(tdata);
      if (tvalid) valid_cycles++;
      if (tvalid && !tvalid_prev) rise_cyc = cyc_cnt;
    end
    tvalid_prev = tvalid;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit chk, output logic [31:0] rd);
    bit ok;
    ok = 1'b0;
    rd = '0;
    tick(1);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (ack) begin
        ok = 1'b1;
        rd = dat_o;
      end
    end
    tick(1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    if (!ok) check("wb_ack_timeout", {31'b0, ok}, 32'd1);
    if (chk) check("wb_ack_pulse", {31'b0, ack}, 32'd0);
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, a, d, s, 1'b0, unused_rd);
  endtask

  task automatic wb_rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, a, 32'h0, 4'hF, 1'b0, rd);
    check(tag, rd, exp);
  endtask

  task automatic configure(input bit cp, input bit ch, input bit lsb, input int nbits);
    wb_wr(32'h0, {28'b0, lsb, ch, cp, 1'b0}, 4'h1);
    wb_wr(32'h4, 32'(nbits - 1), 4'h1);
    wb_wr(32'h0, {28'b0, lsb, ch, cp, 1'b1}, 4'h1);
  endtask

  // Sends the first `total` bits of the words in tx_q, nbits per word
  task automatic spi_frame(input bit cp, input bit ch, input bit lsb, input int nbits,
                           input int total, input bit keep_cs);
    logic [31:0] w;
    int          i;
    bit          bitv;
    sclk = cp;
    tick(H);
    cs_n = 1'b0;
    tick(H);
    for (int b = 0; b < total; b++) begin
      w    = tx_q[b / nbits];
      i    = b % nbits;
      bitv = lsb ? w[i] : w[nbits-1-i];
      if (!ch) begin
        sdi = bitv;
        tick(H);
        sclk = ~sclk;
        last_sample_cyc = cyc_cnt;
        tick(H);
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        sdi  = bitv;
        tick(H);
        sclk = ~sclk;
        last_sample_cyc = cyc_cnt;
        tick(H);
      end
    end
    if (!keep_cs) begin
      tick(H);
      cs_n = 1'b1;
      tick(H + 6);
    end
  endtask

  initial begin
    bit          cp, ch, lsb;
    int          nbits, nw;
    logic [31:0] w, mask, rd;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    dat_i = '0; adr = '0; sclk = 1'b0; cs_n = 1'b1; sdi = 1'b0; tready = 1'b1;
    valid_cycles = 0; rise_cyc = -1; last_sample_cyc = 0;

    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_tvalid", {31'b0, tvalid}, 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat_o", dat_o, 32'd0);
    tick(1);
    rst = 1'b0;
    wb_rd_check("rst_wsize", 32'h4, 32'h1F);
    wb_rd_check("rst_ctrl", 32'h0, 32'h0);
    wb_rd_check("rst_status", 32'h8, 32'h0);
    wb_rd_check("rst_last", 32'hC, 32'h0);

    // Register access, ack pulse width and byte enables
    wb_xfer(1'b1, 32'h0, 32'h1, 4'b0001, 1'b1, rd);
    wb_xfer(1'b0, 32'h0, 32'h0, 4'hF, 1'b1, rd);
    check("ctrl_readback", rd, 32'h1);
    wb_wr(32'h0, 32'hE, 4'b0010);
    wb_rd_check("ctrl_sel_masked", 32'h0, 32'h1);
    wb_wr(32'h0, 32'h0, 4'h1);

    // Mode 0, 8-bit MSB-first 0xA5
    got_q.delete(); tx_q.delete();
    tx_q.push_back(32'hA5);
    configure(1'b0, 1'b0, 1'b0, 8);
    valid_cycles = 0;
    spi_frame(1'b0, 1'b0, 1'b0, 8, 8, 1'b0);
    check("m0_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("m0_word", got_q[0], 32'hA5);
    check("m0_valid_cycles", valid_cycles, 32'd1);
    wb_rd_check("m0_last", 32'hC, 32'hA5);

    // Mode 3, 32-bit LSB-first, latency from final sample edge
    got_q.delete(); tx_q.delete();
    tx_q.push_back(32'hDEADBEEF);
    configure(1'b1, 1'b1, 1'b1, 32);
    rise_cyc = -1;
    spi_frame(1'b1, 1'b1, 1'b1, 32, 32, 1'b0);
    check("m3_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("m3_word", got_q[0], 32'hDEADBEEF);
    check("m3_latency", rise_cyc - last_sample_cyc, 32'd3);

    // Overflow with tready low
    got_q.delete(); tx_q.delete();
    tready = 1'b0;
    tx_q.push_back(32'h11); tx_q.push_back(32'h22);
    configure(1'b0, 1'b0, 1'b0, 8);
    spi_frame(1'b0, 1'b0, 1'b0, 8, 16, 1'b0);
    @(negedge clk);
    check("ovf_tvalid", {31'b0, tvalid}, 32'd1);
    check("ovf_tdata", tdata, 32'h11);
    wb_rd_check("ovf_status", 32'h8, 32'h1);
    wb_rd_check("ovf_last", 32'hC, 32'h11);
    wb_wr(32'h8, 32'h1, 4'h1);
    wb_rd_check("ovf_w1c", 32'h8, 32'h0);
    tready = 1'b1;
    tick(3);
    check("ovf_drain_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("ovf_drain_word", got_q[0], 32'h11);

    // Frame error: cs_n rises after 5 of 8 bits
    got_q.delete(); tx_q.delete();
    tx_q.push_back(32'h3C);
    spi_frame(1'b0, 1'b0, 1'b0, 8, 5, 1'b1);
    wb_rd_check("ferr_busy", 32'h8, 32'h4);
    tick(H);
    cs_n = 1'b1;
    tick(H + 6);
    check("ferr_no_word", got_q.size(), 32'd0);
    wb_rd_check("ferr_status", 32'h8, 32'h2);
    wb_wr(32'h8, 32'h2, 4'h1);
    spi_frame(1'b0, 1'b0, 1'b0, 8, 8, 1'b0);
    check("ferr_next_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("ferr_next_word", got_q[0], 32'h3C);
    wb_rd_check("ferr_cleared", 32'h8, 32'h0);

    // Randomised frames: mode, bit order, size and word count
    for (int it = 0; it < 6; it++) begin
      cp    = 1'($urandom_range(0, 1));
      ch    = 1'($urandom_range(0, 1));
      lsb   = 1'($urandom_range(0, 1));
      nbits = int'($urandom_range(1, 32));
      nw    = int'($urandom_range(1, 3));
      mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'h1 << nbits) - 32'h1);
      got_q.delete(); tx_q.delete(); exp_q.delete();
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        tx_q.push_back(w);
        exp_q.push_back(w & mask);
      end
      configure(cp, ch, lsb, nbits);
      spi_frame(cp, ch, lsb, nbits, nbits * nw, 1'b0);
      check("rand_count", got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k < got_q.size()) check("rand_word", got_q[k], exp_q[k]);
      end
      wb_rd_check("rand_last", 32'hC, exp_q[exp_q.size()-1]);
      wb_rd_check("rand_status", 32'h8, 32'h0);
    end

    // Reset in the middle of a word
    got_q.delete(); tx_q.delete();
    tx_q.push_back(32'h55);
    configure(1'b0, 1'b0, 1'b0, 8);
    spi_frame(1'b0, 1'b0, 1'b0, 8, 4, 1'b1);
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    check("mid_rst_tvalid", {31'b0, tvalid}, 32'd0);
    check("mid_rst_tdata", tdata, 32'd0);
    check("mid_rst_ack", {31'b0, ack}, 32'd0);
    check("mid_rst_dat_o", dat_o, 32'd0);
    tick(1);
    rst = 1'b0;
    cs_n = 1'b1;
    tick(H + 4);
    wb_rd_check("mid_rst_ctrl", 32'h0, 32'h0);
    wb_rd_check("mid_rst_wsize", 32'h4, 32'h1F);
    wb_rd_check("mid_rst_status", 32'h8, 32'h0);
    got_q.delete(); tx_q.delete();
    tx_q.push_back(32'h7E);
    configure(1'b0, 1'b0, 1'b0, 8);
    spi_frame(1'b0, 1'b0, 1'b0, 8, 8, 1'b0);
    check("post_rst_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("post_rst_word", got_q[0], 32'h7E);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wfg_record_spi_top.md
Name: wfg_record_spi_top

Overview:
- SPI receiver (slave-side capture) for the waveform generator; the inverse of the SPI drive block.
- Oversamples an externally driven SPI link (sclk, cs_n, sdi) in the Wishbone clock domain.
- Deserialises words of 1..32 bits and presents each word on an AXI-Stream master port.
- Configured and monitored through a 16-byte Wishbone register page.

Parameters:
- BUSW, 32, Wishbone address/data width.
- SYNC_STAGES, 2, synchroniser depth for sclk/cs_n/sdi (>=2).

Ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_stb_i  in  1  Wishbone strobe (already page-qualified by interconnect)
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte enables
- wbs_dat_i  in  BUSW  write data
- wbs_adr_i  in  BUSW  byte address; only [3:2] decoded
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  BUSW  read data
- wfg_record_spi_sclk_i  in  1  async SPI clock
- wfg_record_spi_cs_ni  in  1  async chip select, active low
- wfg_record_spi_sdi_i  in  1  async serial data
- wfg_axis_tready_i  in  1  downstream ready
- wfg_axis_tvalid_o  out  1  word valid
- wfg_axis_tdata_o  out  32  received word, right-justified, upper bits zero

Behaviour:
- Reset values: ack 0, dat_o 0, tvalid 0, tdata 0, CTRL 0, WSIZE 0x1F, STATUS 0, LAST 0, FSM IDLE, bit count 0, synchroniser flops 1 for cs_n, 0 otherwise.
- Registers:
  - 0x0 CTRL RW: [0] en, [1] cpol, [2] cpha, [3] lsb_first.
  - 0x4 WSIZE RW: [4:0] = bits-1.
  - 0x8 STATUS: [0] overflow W1C, [1] frame_err W1C, [2] busy RO.
  - 0xC LAST RO: last word loaded to AXIS.
  - Byte enables honoured on writes.
- Wishbone: ack <= stb & cyc & !ack. Ack is a one-cycle pulse, one cycle after strobe. dat_o is registered alongside ack.
- Synchronisation and edge detection:
  - sclk, cs_n and sdi each pass through SYNC_STAGES flops, so sdi stays aligned to sclk.
  - Edges are detected against one extra sclk history flop.
  - Sample edge is rising when cpol^cpha==0, falling otherwise.
- Input timing requirement: sclk high and low phases each >=2 wb_clk cycles.
- FSM:
  - IDLE: waits for synced cs_n==0 with en=1 -> SHIFT; clears bit count and shift register.
  - SHIFT, on sample edge:
    - MSB-first: shift left, sdi inserted at LSB.
    - lsb_first: sdi written to bit position count.
    - count increments.
  - Word complete (count==WSIZE on the sample edge):
    - Word is loaded to the output stage on the same edge; count resets to 0.
    - FSM stays in SHIFT, so continuous multi-word frames are allowed.
  - cs_n rises in SHIFT:
    - With count!=0, the partial word is discarded and frame_err is set.
    - Either way -> IDLE.
  - en cleared -> IDLE immediately, partial word discarded, no error flag.
- busy = (state==SHIFT).
- Output stage: single register, AXIS rules.
  - tvalid holds until tvalid&tready; tdata is stable while tvalid is high.
  - On word complete:
    - If !tvalid, or tvalid&tready in the same cycle: tdata/LAST load, tvalid=1.
    - Else: the word is dropped, overflow is set, and tvalid/tdata are unchanged.
- Latency: SYNC_STAGES+1 wb_clk edges from the first edge capturing the final sclk sample edge to tvalid=1. This is 3 edges at the default SYNC_STAGES=2.
- Simultaneous events:
  - W1C and a new set in the same cycle: set wins.
  - Clearing en does not drop a pending tvalid word.
- Register writes to cpol/cpha/WSIZE/lsb_first take effect immediately. Software changes them only with en=0.
- Reset mid-frame returns everything to reset values. The next frame starts only after cs_n is seen high, then low.

Decomposition:
- Package wfg_record_spi_pkg holds:
  - register offsets (0x0/0x4/0x8/0xC);
  - CTRL/STATUS bit indices;
  - WSIZE reset constant;
  - FSM enum {IDLE, SHIFT}.
- Sub-module wfg_record_spi_wishbone_reg contains the register file, ack generation, W1C handling and read mux.
- The top contains the synchroniser, FSM, shifter and AXIS stage.

Test Plan:
- Mode 0, WSIZE=7, MSB-first, sdi=0xA5, tready=1 -> tvalid one cycle with tdata=0x000000A5; LAST reads 0xA5.
- Mode 3, WSIZE=31, lsb_first, serial 0xDEADBEEF LSB-first -> tdata=0xDEADBEEF exactly 3 cycles after the last sample edge.
- tready=0, two 8-bit words 0x11, 0x22 in one frame -> tdata stays 0x11, STATUS[0]=1; writing 0x1 to STATUS clears it.
- cs_n rises after 5 of 8 bits -> no tvalid, STATUS[1]=1, busy=0; the next full frame of 0x3C is received correctly.
- Wishbone write CTRL=0x1 with sel=4'b0001, read back -> ack is a single-cycle pulse, data 0x1. Reading WSIZE after reset -> 0x1F.
- Assert wb_rst_i mid-word -> all outputs 0. A later frame with en=1 of 0x7E -> tdata=0x7E.
